// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared opcode/funct constants, FSM state encodings and
//                scoreboard entry type for the five-stage pipeline controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // Opcodes recognised by the hazard classifier
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_halt  = 6'b111111;

    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;

    // FSM state encodings (also visible on ctl_out_state)
    localparam logic [2:0] c_st_rst    = 3'd0;
    localparam logic [2:0] c_st_fill   = 3'd1;
    localparam logic [2:0] c_st_run    = 3'd2;
    localparam logic [2:0] c_st_pause  = 3'd3;
    localparam logic [2:0] c_st_step   = 3'd4;
    localparam logic [2:0] c_st_drain  = 3'd5;
    localparam logic [2:0] c_st_halted = 3'd6;

    localparam logic [31:0] c_nop = 32'b0;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sb_entry_t;

    // True when an in-flight entry will write the given source register
    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] src);
        return e.valid && (e.dest == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_decode_regs.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_decode_regs
//  Description : Combinational register-usage classifier for the instruction
//                held in ID: which sources are read, which destination is
//                written, and whether it is the halt opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_decode_regs
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = c_op_halt
) (
    input  logic [31:0] i_ir,
    output logic        o_src_rs_used,
    output logic        o_src_rt_used,
    output logic        o_dest_valid,
    output logic [4:0]  o_dest,
    output logic        o_is_halt
);

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [5:0] w_funct;
    logic [4:0] w_dest;
    logic       w_dest_en;
    logic       w_unused_shamt;

    assign w_op           = i_ir[31:26];
    assign w_rs           = i_ir[25:21];
    assign w_rt           = i_ir[20:16];
    assign w_rd           = i_ir[15:11];
    assign w_funct        = i_ir[5:0];
    assign w_unused_shamt = ^{i_ir[10:6], w_rs};

    always_comb begin
        o_src_rs_used = 1'b0;
        o_src_rt_used = 1'b0;
        o_is_halt     = 1'b0;
        w_dest        = 5'd0;
        w_dest_en     = 1'b0;
        // The all-zero word is the pipeline bubble and never touches registers
        if (i_ir != c_nop) begin
            if (w_op == HALT_OP) begin
                o_is_halt = 1'b1;
            end else begin
                case (w_op)
                    c_op_rtype: begin
                        if ((w_funct == c_fn_add) || (w_funct == c_fn_sub)) begin
                            o_src_rs_used = 1'b1;
                            o_src_rt_used = 1'b1;
                            w_dest        = w_rd;
                            w_dest_en     = 1'b1;
                        end
                    end
                    c_op_addi, c_op_lw: begin
                        o_src_rs_used = 1'b1;
                        w_dest        = w_rt;
                        w_dest_en     = 1'b1;
                    end
                    c_op_sw, c_op_beq: begin
                        o_src_rs_used = 1'b1;
                        o_src_rt_used = 1'b1;
                    end
                    c_op_j: begin
                        w_dest_en = 1'b0;
                    end
                    default: begin
                        w_dest_en = 1'b0;
                    end
                endcase
            end
        end
    end

    // $0 is hardwired, so writing it never creates a dependence
    assign o_dest_valid = w_dest_en && (w_dest != 5'd0);
    assign o_dest       = o_dest_valid ? w_dest : 5'd0;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Run/pause/step/halt sequencer and RAW-hazard scoreboard for
//                a five-stage MIPS pipeline without forwarding. Drives the
//                PC, IR_1 and inter-stage register enables, bubble and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int         CNT_W   = 16,
    parameter logic [5:0] HALT_OP = c_op_halt
) (
    input  logic             ctl_in_clk,
    input  logic             ctl_in_rst,
    input  logic             ctl_in_run,
    input  logic             ctl_in_step,
    input  logic [31:0]      ctl_in_ir_id,
    input  logic             ctl_in_redirect,
    output logic             ctl_out_pc_en,
    output logic             ctl_out_ifid_en,
    output logic             ctl_out_adv,
    output logic             ctl_out_bubble,
    output logic             ctl_out_flush,
    output logic [2:0]       ctl_out_state,
    output logic [CNT_W-1:0] ctl_out_stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_step_prev;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;

    sb_entry_t        r_sb_ex;
    sb_entry_t        r_sb_mem;
    sb_entry_t        r_sb_wb;
    sb_entry_t        w_sb_ex_nxt;
    sb_entry_t        w_sb_mem_nxt;
    sb_entry_t        w_sb_wb_nxt;

    logic             w_src_rs_used;
    logic             w_src_rt_used;
    logic             w_dest_valid;
    logic [4:0]       w_dest;
    logic             w_is_halt;

    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic             w_rs_hit;
    logic             w_rt_hit;
    logic             w_hazard;
    logic             w_sb_empty;
    logic             w_step_rise;

    logic             w_pc_en;
    logic             w_ifid_en;
    logic             w_adv;
    logic             w_bubble;
    logic             w_flush;
    logic             w_stall;

    pipeline_decode_regs #(
        .HALT_OP (HALT_OP)
    ) u_decode (
        .i_ir          (ctl_in_ir_id),
        .o_src_rs_used (w_src_rs_used),
        .o_src_rt_used (w_src_rt_used),
        .o_dest_valid  (w_dest_valid),
        .o_dest        (w_dest),
        .o_is_halt     (w_is_halt)
    );

    assign w_rs = ctl_in_ir_id[25:21];
    assign w_rt = ctl_in_ir_id[20:16];

    // Register writes land one cycle after WB, so all three entries matter
    assign w_rs_hit = w_src_rs_used && (w_rs != 5'd0) &&
                      (sb_hit(r_sb_ex, w_rs) || sb_hit(r_sb_mem, w_rs) || sb_hit(r_sb_wb, w_rs));
    assign w_rt_hit = w_src_rt_used && (w_rt != 5'd0) &&
                      (sb_hit(r_sb_ex, w_rt) || sb_hit(r_sb_mem, w_rt) || sb_hit(r_sb_wb, w_rt));
    assign w_hazard = w_rs_hit || w_rt_hit;

    assign w_sb_empty  = !(r_sb_ex.valid || r_sb_mem.valid || r_sb_wb.valid);
    assign w_step_rise = ctl_in_step && !r_step_prev;

    always_comb begin
        w_pc_en     = 1'b0;
        w_ifid_en   = 1'b0;
        w_adv       = 1'b0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        w_stall     = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_st_rst: begin
                w_state_nxt = c_st_fill;
            end
            c_st_fill: begin
                w_pc_en     = 1'b1;
                w_state_nxt = ctl_in_run ? c_st_run : c_st_pause;
            end
            c_st_run, c_st_step: begin
                w_adv       = 1'b1;
                w_state_nxt = ((r_state == c_st_step) || !ctl_in_run) ? c_st_pause : c_st_run;
                // Redirect discards the ID instruction, so it outranks halt and hazard
                if (ctl_in_redirect) begin
                    w_pc_en   = 1'b1;
                    w_ifid_en = 1'b1;
                    w_bubble  = 1'b1;
                    w_flush   = 1'b1;
                end else if (w_is_halt) begin
                    w_bubble    = 1'b1;
                    w_state_nxt = c_st_drain;
                end else if (w_hazard) begin
                    w_bubble = 1'b1;
                    w_stall  = 1'b1;
                end else begin
                    w_pc_en   = 1'b1;
                    w_ifid_en = 1'b1;
                end
            end
            c_st_pause: begin
                if (ctl_in_run) begin
                    w_state_nxt = c_st_run;
                end else if (w_step_rise) begin
                    w_state_nxt = c_st_step;
                end
            end
            c_st_drain: begin
                w_adv    = 1'b1;
                w_bubble = 1'b1;
                if (w_sb_empty) begin
                    w_state_nxt = c_st_halted;
                end
            end
            c_st_halted: begin
                w_state_nxt = c_st_halted;
            end
            default: begin
                w_state_nxt = c_st_rst;
            end
        endcase
    end

    always_comb begin
        w_sb_ex_nxt  = r_sb_ex;
        w_sb_mem_nxt = r_sb_mem;
        w_sb_wb_nxt  = r_sb_wb;
        if (w_adv) begin
            w_sb_wb_nxt  = r_sb_mem;
            w_sb_mem_nxt = r_sb_ex;
            if (w_bubble || w_flush || !w_dest_valid) begin
                w_sb_ex_nxt = '0;
            end else begin
                w_sb_ex_nxt.valid = 1'b1;
                w_sb_ex_nxt.dest  = w_dest;
            end
        end
    end

    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            w_stall_cnt_nxt = r_stall_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge ctl_in_clk) begin
        if (ctl_in_rst) begin
            r_state     <= c_st_rst;
            r_step_prev <= 1'b0;
            r_stall_cnt <= '0;
            r_sb_ex     <= '0;
            r_sb_mem    <= '0;
            r_sb_wb     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_prev <= ctl_in_step;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_sb_ex     <= w_sb_ex_nxt;
            r_sb_mem    <= w_sb_mem_nxt;
            r_sb_wb     <= w_sb_wb_nxt;
        end
    end

    assign ctl_out_pc_en     = w_pc_en;
    assign ctl_out_ifid_en   = w_ifid_en;
    assign ctl_out_adv       = w_adv;
    assign ctl_out_bubble    = w_bubble;
    assign ctl_out_flush     = w_flush;
    assign ctl_out_state     = r_state;
    assign ctl_out_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl: directed vector table
//                followed by randomized stimulus against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] ADD3   = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] ADD4   = 32'h0063_2020;  // add $4,$3,$3
    localparam logic [31:0] ADDI0  = 32'h2000_0005;  // addi $0,$0,5
    localparam logic [31:0] ADD400 = 32'h0000_2020;  // add $4,$0,$0
    localparam logic [31:0] LW5    = 32'h8C25_0000;  // lw $5,0($1)
    localparam logic [31:0] HALT   = 32'hFC00_0000;
    localparam logic [31:0] ADD655 = 32'h00A5_3020;  // add $6,$5,$5

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             redir = 1'b0;
    logic [31:0]      ir = 32'h0;
    logic             pc_en, ifid_en, adv, bubble, flush;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: register 0 doubles as "no register"
    int m_state = 0;
    int m_sb[3] = '{0, 0, 0};
    int m_cnt   = 0;
    bit m_step_prev = 1'b0;

    typedef struct packed {
        logic        rst;
        logic        run;
        logic        step;
        logic [31:0] ir;
        logic        redir;
        logic [4:0]  en;     // {pc_en, ifid_en, adv, bubble, flush}
        logic [2:0]  st;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .CNT_W   (CNT_W),
        .HALT_OP (6'b111111)
    ) dut (
        .ctl_in_clk        (clk),
        .ctl_in_rst        (rst),
        .ctl_in_run        (run),
        .ctl_in_step       (step),
        .ctl_in_ir_id      (ir),
        .ctl_in_redirect   (redir),
        .ctl_out_pc_en     (pc_en),
        .ctl_out_ifid_en   (ifid_en),
        .ctl_out_adv       (adv),
        .ctl_out_bubble    (bubble),
        .ctl_out_flush     (flush),
        .ctl_out_state     (state),
        .ctl_out_stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic addv(input logic r, input logic ru, input logic st, input logic [31:0] i,
                        input logic rd, input logic [4:0] en, input logic [2:0] s, input logic [3:0] c);
        vec_t v;
        v = '{rst: r, run: ru, step: st, ir: i, redir: rd, en: en, st: s, cnt: c};
        tbl.push_back(v);
    endtask

    task automatic decode(input logic [31:0] w, output int s1, output int s2, output int d, output bit h);
        int op, fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        s1 = 0; s2 = 0; d = 0; h = 1'b0;
        if (op == 0 && (fn == 32 || fn == 34) && w != 0) begin
            s1 = int'(w[25:21]); s2 = int'(w[20:16]); d = int'(w[15:11]);
        end else if (op == 8 || op == 35) begin
            s1 = int'(w[25:21]); d = int'(w[20:16]);
        end else if (op == 43 || op == 4) begin
            s1 = int'(w[25:21]); s2 = int'(w[20:16]);
        end else if (op == 63) begin
            h = 1'b1;
        end
    endtask

    function automatic bit in_flight(input int r);
        return (r != 0) && (m_sb[0] == r || m_sb[1] == r || m_sb[2] == r);
    endfunction

    // Evaluates expected outputs for the current inputs and commits the model.
    task automatic model_cycle(output logic [4:0] e_en, output logic [2:0] e_st, output logic [3:0] e_cnt);
        int  s1, s2, d, nxt, push;
        bit  h, inc;
        decode(ir, s1, s2, d, h);
        e_en  = 5'b00000;
        e_st  = 3'(m_state);
        e_cnt = 4'(m_cnt);
        nxt   = m_state;
        push  = -1;
        inc   = 1'b0;
        if (m_state == 0) begin
            nxt = 1;
        end else if (m_state == 1) begin
            e_en = 5'b10000;
            nxt  = run ? 2 : 3;
        end else if (m_state == 2 || m_state == 4) begin
            nxt = (m_state == 4 || !run) ? 3 : 2;
            if (redir) begin
                e_en = 5'b11111; push = 0;
            end else if (h) begin
                e_en = 5'b00110; push = 0; nxt = 5;
            end else if (in_flight(s1) || in_flight(s2)) begin
                e_en = 5'b00110; push = 0; inc = 1'b1;
            end else begin
                e_en = 5'b11100; push = d;
            end
        end else if (m_state == 3) begin
            if (run) nxt = 2;
            else if (step && !m_step_prev) nxt = 4;
        end else if (m_state == 5) begin
            e_en = 5'b00110; push = 0;
            if (m_sb[0] == 0 && m_sb[1] == 0 && m_sb[2] == 0) nxt = 6;
        end
        if (rst) begin
            m_state = 0; m_sb = '{0, 0, 0}; m_cnt = 0;
        end else begin
            if (push >= 0) begin
                m_sb[2] = m_sb[1]; m_sb[1] = m_sb[0]; m_sb[0] = push;
            end
            if (inc && m_cnt < CMAX) m_cnt++;
            m_state = nxt;
        end
        m_step_prev = rst ? 1'b0 : step;
    endtask

    function automatic logic [31:0] rand_ir();
        int k;
        logic [4:0] a, b, c;
        k = $urandom_range(0, 39);
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        if (k < 10)      return {6'h00, a, b, c, 5'd0, 6'h20};
        else if (k < 14) return {6'h00, a, b, c, 5'd0, 6'h22};
        else if (k < 18) return {6'h08, a, b, 16'h0005};
        else if (k < 22) return {6'h23, a, b, 16'h0010};
        else if (k < 25) return {6'h2b, a, b, 16'h0004};
        else if (k < 28) return {6'h04, a, b, 16'h0002};
        else if (k < 30) return {6'h02, 26'h0000040};
        else if (k == 30) return HALT;
        else if (k < 33) return {6'h0d, a, b, 16'h00ff};
        else if (k < 35) return {6'h00, a, b, c, 5'd0, 6'h25};
        else             return NOP;
    endfunction

    initial begin
        logic [4:0] e_en;
        logic [2:0] e_st;
        logic [3:0] e_cnt;
        int         halted_for;

        // rst run step ir redir | {pc,ifid,adv,bub,fl} state cnt
        addv(1, 1, 0, NOP,    0, 5'b00000, 0, 0);
        addv(0, 1, 0, NOP,    0, 5'b00000, 0, 0);
        addv(0, 1, 0, NOP,    0, 5'b10000, 1, 0);
        addv(0, 1, 0, ADD3,   0, 5'b11100, 2, 0);
        addv(0, 1, 0, ADD4,   0, 5'b00110, 2, 0);
        addv(0, 1, 0, ADD4,   0, 5'b00110, 2, 1);
        addv(0, 1, 0, ADD4,   0, 5'b00110, 2, 2);
        addv(0, 1, 0, ADD4,   0, 5'b11100, 2, 3);
        addv(0, 1, 0, ADDI0,  0, 5'b11100, 2, 3);
        addv(0, 1, 0, ADD400, 0, 5'b11100, 2, 3);
        for (int i = 0; i < 3; i++) addv(0, 1, 0, NOP, 0, 5'b11100, 2, 3);
        addv(0, 1, 0, ADD3,   0, 5'b11100, 2, 3);
        addv(0, 1, 0, ADD4,   1, 5'b11111, 2, 3);
        addv(0, 1, 0, NOP,    0, 5'b11100, 2, 3);
        addv(0, 1, 0, NOP,    0, 5'b11100, 2, 3);
        addv(0, 0, 0, NOP,    0, 5'b11100, 2, 3);
        addv(0, 0, 0, NOP,    0, 5'b00000, 3, 3);
        addv(0, 0, 1, NOP,    0, 5'b00000, 3, 3);
        addv(0, 0, 1, NOP,    0, 5'b11100, 4, 3);
        for (int i = 0; i < 3; i++) addv(0, 0, 1, NOP, 0, 5'b00000, 3, 3);
        addv(0, 0, 0, NOP,    0, 5'b00000, 3, 3);
        addv(0, 1, 1, NOP,    0, 5'b00000, 3, 3);
        addv(0, 1, 0, LW5,    0, 5'b11100, 2, 3);
        addv(0, 1, 0, HALT,   0, 5'b00110, 2, 3);
        addv(0, 0, 0, HALT,   0, 5'b00110, 5, 3);
        addv(0, 1, 0, HALT,   0, 5'b00110, 5, 3);
        addv(0, 0, 0, HALT,   0, 5'b00110, 5, 3);
        addv(0, 1, 0, HALT,   0, 5'b00000, 6, 3);
        addv(0, 0, 0, HALT,   0, 5'b00000, 6, 3);
        addv(0, 1, 1, HALT,   0, 5'b00000, 6, 3);
        addv(1, 1, 0, HALT,   0, 5'b00000, 6, 3);
        addv(0, 1, 0, NOP,    0, 5'b00000, 0, 0);
        addv(0, 1, 0, NOP,    0, 5'b10000, 1, 0);
        addv(0, 1, 0, LW5,    0, 5'b11100, 2, 0);
        addv(0, 1, 0, HALT,   0, 5'b00110, 2, 0);
        addv(0, 1, 0, HALT,   0, 5'b00110, 5, 0);
        addv(1, 1, 0, HALT,   0, 5'b00110, 5, 0);
        addv(0, 1, 0, NOP,    0, 5'b00000, 0, 0);
        addv(0, 1, 0, NOP,    0, 5'b10000, 1, 0);
        addv(0, 1, 0, ADD655, 0, 5'b11100, 2, 0);

        // Initial reset, keeping the model in step
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            model_cycle(e_en, e_st, e_cnt);
            @(posedge clk); #1;
        end

        foreach (tbl[i]) begin
            rst = tbl[i].rst; run = tbl[i].run; step = tbl[i].step;
            ir = tbl[i].ir; redir = tbl[i].redir;
            @(negedge clk);
            chk($sformatf("vec%0d_en", i), {27'd0, pc_en, ifid_en, adv, bubble, flush}, {27'd0, tbl[i].en});
            chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
            chk($sformatf("vec%0d_cnt", i), {28'd0, stall_cnt}, {28'd0, tbl[i].cnt});
            model_cycle(e_en, e_st, e_cnt);
            @(posedge clk); #1;
        end

        halted_for = 0;
        for (int n = 0; n < 4000; n++) begin
            halted_for = (m_state == 6) ? halted_for + 1 : 0;
            rst   = ($urandom_range(0, 299) == 0) || (halted_for > 4);
            run   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) step = ~step;
            redir = ($urandom_range(0, 9) == 0);
            ir    = rand_ir();
            @(negedge clk);
            model_cycle(e_en, e_st, e_cnt);
            chk($sformatf("rand%0d", n),
                {20'd0, pc_en, ifid_en, adv, bubble, flush, state, stall_cnt},
                {20'd0, e_en, e_st, e_cnt});
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing and hazard controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It owns run, pause, single-step and halt of the whole pipeline. It tracks in-flight destination registers in a three-entry scoreboard and stalls decode on read-after-write hazards, because the datapath has no forwarding. It also flushes the two youngest stages when EX redirects the PC. It sits beside the datapath and drives the enable, bubble and flush controls of PC, IR_1 and the ID/EX, EX/MEM and MEM/WB registers.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall counter.
- HALT_OP, 6'b111111, opcode that halts the pipeline.

Ports:
- ctl_in_clk  in  1  pipeline clock (the slow board clock).
- ctl_in_rst  in  1  synchronous, active-high reset.
- ctl_in_run  in  1  level; 1 = free-run, 0 = pause.
- ctl_in_step  in  1  level; each rising edge while paused advances one cycle.
- ctl_in_ir_id  in  32  instruction currently in ID (IR_1).
- ctl_in_redirect  in  1  EX has a taken beq or a jump this cycle.
- ctl_out_pc_en  out  1  PC may load.
- ctl_out_ifid_en  out  1  IR_1 may load.
- ctl_out_adv  out  1  ID/EX, EX/MEM and MEM/WB registers advance.
- ctl_out_bubble  out  1  load a NOP (32'b0) into ID/EX instead of IR_1.
- ctl_out_flush  out  1  load 32'b0 into IR_1.
- ctl_out_state  out  3  FSM state encoding.
- ctl_out_stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- FSM states:
  - RST=0 is entered on reset.
  - FILL=1 lasts exactly one cycle. pc_en=1 and all other enables are 0, which covers the instruction-memory read latency.
  - After FILL the FSM goes to RUN=2 if run=1, else PAUSE=3.
  - RUN: goes to PAUSE when run=0.
  - PAUSE: goes to STEP=4 on a step rising edge, or to RUN when run=1.
  - STEP: one advance cycle, then back to PAUSE.
  - A valid HALT_OP in ID in RUN or STEP moves the FSM to DRAIN=5.
  - DRAIN: pc_en=0, ifid_en=0, adv=1, bubble=1. It stays until the scoreboard is empty, then goes to HALTED=6.
  - HALTED: every enable is 0. Only reset leaves this state.
- Advance cycle: occurs in RUN, in STEP, and in DRAIN for adv only. In PAUSE, RST and HALTED every enable is 0 and the scoreboard holds.
- Decode classification of ctl_in_ir_id:
  - add/sub (op 0, funct 100000/100010): reads rs and rt, writes rd.
  - addi (001000) and lw (100011): read rs, write rt.
  - sw (101011) and beq (000100): read rs and rt, write nothing.
  - j (000010): reads and writes nothing.
  - Any other encoding is a NOP.
  - A destination of register 0 is never recorded.
- Scoreboard: entries EX, MEM and WB, each {valid, dest[4:0]}. On advance: WB <= MEM, MEM <= EX, EX <= ID destination, or invalid if bubble or flush.
- Hazard: a source of the ID instruction equals a valid scoreboard dest, and that source is nonzero.
  - On hazard in an advance cycle: pc_en=0, ifid_en=0, adv=1, bubble=1.
  - Each such cycle increments the stall counter, saturating at all-ones.
- Redirect: flush=1, bubble=1, pc_en=1. ifid_en=1 with flush forcing IR_1 to zero. The ID instruction is discarded.
  - Redirect has priority over hazard and over HALT_OP detection in ID.
- Register-file writes are visible one cycle after WB, so a hazard persists while the producer sits in any of the three entries.

## Timing
- Reset values:
  - state=RST; scoreboard all invalid; stall_cnt=0.
  - pc_en, ifid_en, adv, bubble and flush all 0.
- Enables are combinational from registered state, the scoreboard, ctl_in_ir_id and ctl_in_redirect. They take effect at the next clock edge.
- Step edge detection uses a registered copy of step. A step held high yields exactly one STEP.
- A step and run=1 arriving in the same cycle: run wins and the FSM goes to RUN.
- A RAW dependence on the immediately preceding instruction costs 3 stall cycles, 2 at distance two and 1 at distance three.
- Reset asserted in any state, including mid-stall or mid-DRAIN, takes effect at the next edge. It clears all state.

## Structure
- A shared package/header holds:
  - the opcode and funct constants (including HALT_OP);
  - the state encodings;
  - the NOP value 32'b0.
- One sub-module, pipeline_decode_regs: a combinational classifier of the ID instruction. It outputs src_rs_used, src_rt_used, dest_valid, dest[4:0] and is_halt.

## Test plan
- add $3,$1,$2 (0x00221820) followed by add $4,$3,$3 (0x00632020) in RUN:
  - 3 consecutive cycles with bubble=1 and pc_en=0;
  - stall_cnt=3;
  - the consumer issues on the 4th cycle.
- addi $0,$0,5 (0x20000005) followed by add $4,$0,$0:
  - no stall;
  - stall_cnt stays 0.
- Dependent pair, then redirect=1 asserted during the hazard:
  - flush=1, bubble=1 and pc_en=1 in that cycle;
  - the stall ends;
  - the scoreboard EX entry is invalid.
- run=0, then a 5-cycle step pulse:
  - exactly one cycle with adv=1;
  - state sequence 3 -> 4 -> 3.
- HALT_OP (0xFC000000) in ID with lw in flight:
  - DRAIN holds until the scoreboard is empty;
  - then HALTED;
  - run toggling has no effect.
- Reset asserted mid-DRAIN:
  - next cycle state=0, all outputs 0;
  - then one FILL cycle with only pc_en=1.
